// File: rtl/tone_gen.sv
// ============================================================================
// Module   : tone_gen
// Brief    : Prescaled square-wave tone generator. The period goes through a
//            one-deep shadow register and is applied only at a half-period
//            boundary. Optional attenuation: define TONE_GEN_ATTEN_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_gen #(
  parameter int WIDTH    = 10,
  parameter int PRESCALE = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] period_in,
  input  logic             load,
  output logic             ready,
  input  logic             enable,
  output logic             out_signal,
  output logic             toggle,
  input  logic [3:0]       atten_in,
  output logic [3:0]       out_level
);

  localparam int              C_PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [C_PW-1:0] C_PRESC_MAX = C_PW'(PRESCALE - 1);

  logic [C_PW-1:0]  presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] period_reg_q, period_reg_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             pending_valid_q, pending_valid_d;
  logic             out_q, out_d;
  logic             toggle_q, toggle_d;
  logic             tick, expire, accept;
  logic [WIDTH-1:0] reload_period;

  always_comb begin
    tick            = enable && (presc_q == C_PRESC_MAX);
    expire          = tick && (cnt_q == '0);
    accept          = load && !pending_valid_q;
    presc_d         = presc_q;
    cnt_d           = cnt_q;
    period_reg_d    = period_reg_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    out_d           = out_q;
    toggle_d        = expire;
    reload_period   = period_reg_q;

    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // A load landing on the expiry cycle bypasses the shadow register.
    if (accept && expire) begin
      reload_period = period_in;
    end else if (pending_valid_q) begin
      reload_period = pending_q;
    end

    if (expire) begin
      out_d           = ~out_q;
      // period 0 wraps to all-ones, i.e. 2**WIDTH ticks.
      cnt_d           = reload_period - 1'b1;
      period_reg_d    = reload_period;
      pending_valid_d = 1'b0;
    end else begin
      if (tick) begin
        cnt_d = cnt_q - 1'b1;
      end
      if (accept) begin
        pending_d       = period_in;
        pending_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q         <= '0;
      cnt_q           <= '0;
      period_reg_q    <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      out_q           <= 1'b0;
      toggle_q        <= 1'b0;
    end else begin
      presc_q         <= presc_d;
      cnt_q           <= cnt_d;
      period_reg_q    <= period_reg_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      out_q           <= out_d;
      toggle_q        <= toggle_d;
    end
  end

  assign ready      = ~pending_valid_q;
  assign out_signal = out_q;
  assign toggle     = toggle_q;

`ifdef TONE_GEN_ATTEN_EN
  logic [3:0] atten_q, atten_d;

  always_comb begin
    atten_d = atten_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      atten_q <= 4'h0;
    end else begin
      atten_q <= atten_d;
    end
  end

  assign out_level = out_q ? ~atten_q : 4'h0;
`else
  logic unused_atten;
  assign unused_atten = ^atten_in;
  assign out_level    = {4{out_q}};
`endif

endmodule

`default_nettype wire
